// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity codes, frame payload and
// data-bits / clocks-per-bit helpers (reused by the receiver).
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    DONE   = ST_DONE
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] data_bits;
    logic [1:0] parity;
    logic       stop2;
  } tx_frame_t;

  localparam int unsigned TX_FRAME_W = $bits(tx_frame_t);

  // 2-bit code 00..11 maps to 5..8 data bits
  function automatic logic [3:0] data_bits_count(input logic [1:0] code);
    return 4'd5 + 4'(code);
  endfunction

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-facing UART TX bus: start/config/data in, line and status out.
interface uart_tx_cfg_if;
  logic       iTxStart;
  logic [7:0] iTxByte;
  logic [1:0] iDataBits;
  logic [1:0] iParity;
  logic       iStop2;
  logic       oTxSerial;
  logic       oTxBusy;
  logic       oTxReady;
  logic       oTxDone;

  modport master (
    output iTxStart, iTxByte, iDataBits, iParity, iStop2,
    input  oTxSerial, oTxBusy, oTxReady, oTxDone
  );

  modport slave (
    input  iTxStart, iTxByte, iDataBits, iParity, iStop2,
    output oTxSerial, oTxBusy, oTxReady, oTxDone
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with show-ahead read data; push while full is accepted
// only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_q == count_d ? count_q : count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, N/E/O parity, 1/2 stop).
// Define UART_TX_FIFO_EN to front it with a uart_tx_fifo frame queue.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 125_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE),
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic          iClk,
  input  logic          iRstN,
  uart_tx_cfg_if.slave  tx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP2_LAST = CNT_W'(2 * CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       nbits_q, nbits_d;
  logic             par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic             serial_q, serial_d, busy_q, busy_d, done_q, done_d;

  tx_frame_t        src;
  logic             src_valid;
  logic [3:0]       src_n;
  logic [7:0]       src_masked;
  logic             bit_end, stop_end;

`ifdef UART_TX_FIFO_EN
  logic      fifo_full, fifo_empty, fifo_pop;
  tx_frame_t wr_frame;

  assign wr_frame  = {tx.iTxByte, tx.iDataBits, tx.iParity, tx.iStop2};
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign src_valid = !fifo_empty;

  uart_tx_fifo #(.WIDTH(TX_FRAME_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (iClk),
    .rst_n (iRstN),
    .push  (tx.iTxStart),
    .pop   (fifo_pop),
    .wdata (wr_frame),
    .rdata (src),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx.oTxReady = !fifo_full;
  assign tx.oTxBusy  = busy_q | !fifo_empty;
`else
  logic ready_q, ready_d;

  assign src       = {tx.iTxByte, tx.iDataBits, tx.iParity, tx.iStop2};
  assign src_valid = tx.iTxStart;
  assign ready_d   = (state_d == IDLE);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) ready_q <= 1'b1;
    else        ready_q <= ready_d;
  end

  assign tx.oTxReady = ready_q;
  assign tx.oTxBusy  = busy_q;
`endif

  assign src_n      = data_bits_count(src.data_bits);
  assign src_masked = src.data & (8'hFF >> (4'd8 - src_n));
  assign bit_end    = (cnt_q == BIT_LAST);
  assign stop_end   = stop2_q ? (cnt_q == STOP2_LAST) : bit_end;

  // Next state plus registered line/status outputs decoded from the next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;

    case (state_q)
      IDLE: begin
        if (src_valid) begin
          state_d   = START;
          cnt_d     = '0;
          bit_d     = '0;
          shift_d   = src_masked;
          nbits_d   = src_n;
          par_en_d  = (src.parity == PAR_EVEN) || (src.parity == PAR_ODD);
          par_bit_d = (^src_masked) ^ (src.parity == PAR_ODD);
          stop2_d   = src.stop2;
        end
      end
      START: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if ({1'b0, bit_q} == nbits_q - 4'd1) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        cnt_d = stop_end ? '0 : cnt_q + CNT_W'(1);
        if (stop_end) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = par_bit_d;
      default: serial_d = 1'b1;
    endcase
    busy_d = (state_d == START) || (state_d == DATA) ||
             (state_d == PARITY) || (state_d == STOP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx.oTxSerial = serial_q;
  assign tx.oTxDone   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: expected line waveforms are built from
// the frame format (start, LSB-first data, parity, stop) at 16 clocks per bit.
module tb_uart_tx_cfg;

  localparam int CPB = 16;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic exp_wave[$];
  logic rec_en = 1'b0;
  logic rec_line[$];
  logic rec_done[$];

  uart_tx_cfg_if bus();

  uart_tx_cfg #(
    .CLK_FREQ     (16 * 115_200),
    .BAUD_RATE    (115_200),
    .CLKS_PER_BIT (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .tx    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rec_en) begin
      rec_line.push_back(bus.oTxSerial);
      rec_done.push_back(bus.oTxDone);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void push_bit(input logic v);
    for (int c = 0; c < CPB; c++) exp_wave.push_back(v);
  endfunction

  // Reference line waveform for one frame; returns its length in cycles
  function automatic int build_wave(input logic [7:0] b, input logic [1:0] db,
                                    input logic [1:0] par, input logic s2);
    int n, masked, ones;
    n      = 5 + int'(db);
    masked = int'(b) % (1 << n);
    ones   = $countones(masked);
    exp_wave.delete();
    push_bit(1'b0);
    for (int i = 0; i < n; i++) push_bit(((masked >> i) & 1) == 1);
    if (par == 2'b01) push_bit((ones % 2) == 1);
    else if (par == 2'b10) push_bit((ones % 2) == 0);
    push_bit(1'b1);
    if (s2) push_bit(1'b1);
    return exp_wave.size();
  endfunction

  task automatic drive(input logic [7:0] b, input logic [1:0] db,
                       input logic [1:0] par, input logic s2);
    bus.iTxByte   = b;
    bus.iDataBits = db;
    bus.iParity   = par;
    bus.iStop2    = s2;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic [1:0] db,
                           input logic [1:0] par, input logic s2, input int inject_at);
    int len, done_at, bad;
    logic line_at_done, busy_at_done;
    len = build_wave(b, db, par, s2);
    done_at = -1;
    bad = 0;
    line_at_done = 1'b0;
    busy_at_done = 1'b1;
    @(negedge clk);
    drive(b, db, par, s2);
    bus.iTxStart = 1'b1;
    @(negedge clk);
    bus.iTxStart = 1'b0;
    repeat (LAT) @(negedge clk);
    for (int k = 0; k < 600; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) check({tag, "_busy_start"}, int'(bus.oTxBusy), 1);
`ifndef UART_TX_FIFO_EN
      if (k == 1) check({tag, "_ready_busy"}, int'(bus.oTxReady), 0);
`endif
      if (k == inject_at) begin
        drive(8'h55, 2'b00, 2'b10, 1'b1);
        bus.iTxStart = 1'b1;
      end else if (k == inject_at + 1) begin
        bus.iTxStart = 1'b0;
      end
      if (bus.oTxDone) begin
        done_at = k;
        line_at_done = bus.oTxSerial;
        busy_at_done = bus.oTxBusy;
        break;
      end
      if (k >= len || bus.oTxSerial !== exp_wave[k]) bad++;
    end
    check({tag, "_done_at"}, done_at, len);
    check({tag, "_wave_bad"}, bad, 0);
    check({tag, "_line_done"}, int'(line_at_done), 1);
    check({tag, "_busy_done"}, int'(busy_at_done), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(bus.oTxDone), 0);
  endtask

  initial begin
    int lows, ndone, first, bad_line, bad_done, len;
    logic exp_line_all[$];
    logic exp_done_all[$];

    bus.iTxStart = 1'b0;
    drive(8'h00, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_serial", int'(bus.oTxSerial), 1);
    check("rst_busy", int'(bus.oTxBusy), 0);
    check("rst_done", int'(bus.oTxDone), 0);
    check("rst_ready", int'(bus.oTxReady), 1);

    run_frame("8n1_a5", 8'hA5, 2'b11, 2'b00, 1'b0, -1);
    run_frame("7e1_41", 8'h41, 2'b10, 2'b01, 1'b0, -1);
    run_frame("7o1_41", 8'h41, 2'b10, 2'b10, 1'b0, -1);
    run_frame("7e1_c1", 8'hC1, 2'b10, 2'b01, 1'b0, -1);
    run_frame("5o2_1f", 8'h1F, 2'b00, 2'b10, 1'b1, -1);
    run_frame("6n2_par11", 8'hEB, 2'b01, 2'b11, 1'b1, -1);

`ifndef UART_TX_FIFO_EN
    run_frame("midframe", 8'h96, 2'b11, 2'b00, 1'b0, 50);
    lows = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.oTxSerial !== 1'b1 || bus.oTxBusy !== 1'b0) lows++;
    end
    check("midframe_no_extra", lows, 0);
`endif

    // Reset asserted in the middle of data bit 3
    drive(8'h5A, 2'b11, 2'b00, 1'b0);
    @(negedge clk);
    bus.iTxStart = 1'b1;
    @(negedge clk);
    bus.iTxStart = 1'b0;
    repeat (LAT) @(negedge clk);
    repeat (71) @(negedge clk);
    check("busy_before_rst", int'(bus.oTxBusy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_serial", int'(bus.oTxSerial), 1);
    check("rst_mid_busy", int'(bus.oTxBusy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", int'(bus.oTxReady), 1);
    run_frame("after_rst_3c", 8'h3C, 2'b11, 2'b00, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      run_frame("rand", 8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), -1);
    end

`ifdef UART_TX_FIFO_EN
    drive(8'h00, 2'b11, 2'b00, 1'b0);
    @(negedge clk);
    rec_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.iTxStart = 1'b1;
      bus.iTxByte  = 8'(i + 1);
      @(negedge clk);
      if (i == 1) check("fifo_first_pop", int'(bus.oTxSerial), 0);
    end
    bus.iTxStart = 1'b0;
    check("fifo_full_ready", int'(bus.oTxReady), 0);
    check("fifo_full_busy", int'(bus.oTxBusy), 1);
    ndone = 0;
    for (int t = 0; t < 2000 && ndone < 5; t++) begin
      @(negedge clk);
      if (bus.oTxDone) ndone++;
    end
    @(negedge clk);
    rec_en = 1'b0;
    check("fifo_ndone", ndone, 5);
    check("fifo_ready_after", int'(bus.oTxReady), 1);

    for (int j = 0; j < 5; j++) begin
      len = build_wave(8'(j + 1), 2'b11, 2'b00, 1'b0);
      for (int k = 0; k < len; k++) begin
        exp_line_all.push_back(exp_wave[k]);
        exp_done_all.push_back(1'b0);
      end
      exp_line_all.push_back(1'b1);
      exp_done_all.push_back(1'b1);
      exp_line_all.push_back(1'b1);
      exp_done_all.push_back(1'b0);
    end
    first = -1;
    foreach (rec_line[i]) begin
      if (first < 0 && rec_line[i] === 1'b0) first = i;
    end
    if (first < 0) first = rec_line.size();
    bad_line = 0;
    bad_done = 0;
    for (int k = 0; k < exp_line_all.size() - 1; k++) begin
      if (first + k >= rec_line.size()) begin
        bad_line++;
        bad_done++;
      end else begin
        if (rec_line[first + k] !== exp_line_all[k]) bad_line++;
        if (rec_done[first + k] !== exp_done_all[k]) bad_done++;
      end
    end
    check("fifo_stream_line", bad_line, 0);
    check("fifo_stream_done", bad_done, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
